// File: rtl/rf_wr_arb.sv
// rf_wr_arb: arbitrates pipeline writebacks against buffered peripheral writes for one register-file write port; 1-cycle latency.
// Peripheral side is backpressured by a 2-entry FIFO (pr_ready); starvation raises stall_req. Optional RF_ARB_ERR_EN: sticky skid-overflow flag.

module rf_wr_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout = mem[rd_ptr];

endmodule

module rf_wr_arb #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic [4:0]  wb_regsel,
  input  logic [31:0] wb_data,
  input  logic        pr_valid,
  output logic        pr_ready,
  input  logic [4:0]  pr_regsel,
  input  logic [31:0] pr_data,
  output logic        rf_write,
  output logic [4:0]  rf_writeregsel,
  output logic [31:0] rf_writedata,
  output logic        stall_req,
  output logic        err
);

  typedef struct packed {
    logic [4:0]  sel;
    logic [31:0] dat;
  } wr_req_t;

  typedef enum logic {NORMAL, FORCE} state_t;

  state_t     state, state_nxt;
  logic [2:0] starve_cnt, starve_cnt_nxt;
  logic       rst_q;
  wr_req_t    skid, skid_nxt;
  logic       skid_vld, skid_vld_nxt;
  wr_req_t    wb_req, pr_req, fifo_head, win;
  logic       win_vld;
  logic [1:0] fifo_cnt;
  logic       fifo_push, fifo_pop, fifo_nonempty;
`ifdef RF_ARB_ERR_EN
  logic       skid_ovf;
  logic       err_q;
`endif

  assign wb_req        = '{sel: wb_regsel, dat: wb_data};
  assign pr_req        = '{sel: pr_regsel, dat: pr_data};
  assign fifo_nonempty = (fifo_cnt != 2'd0);
  // Registered count only: a pop while full frees the slot for the next cycle, not this one.
  assign pr_ready      = !rst_q && (fifo_cnt < 2'd2);
  assign fifo_push     = pr_valid && pr_ready;
  assign stall_req     = (state == FORCE);

  rf_wr_fifo #(
    .WIDTH ($bits(wr_req_t)),
    .DEPTH (2)
  ) u_pr_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (pr_req),
    .dout  (fifo_head),
    .count (fifo_cnt)
  );

  always_comb begin
    state_nxt      = state;
    starve_cnt_nxt = starve_cnt;
    skid_nxt       = skid;
    skid_vld_nxt   = skid_vld;
    win            = '0;
    win_vld        = 1'b0;
    fifo_pop       = 1'b0;
`ifdef RF_ARB_ERR_EN
    skid_ovf       = 1'b0;
`endif
    case (state)
      NORMAL: begin
        if (skid_vld) begin
          // Skid drains first; a writeback arriving now takes its place so none is lost.
          win          = skid;
          win_vld      = 1'b1;
          skid_vld_nxt = wb_valid;
          if (wb_valid) skid_nxt = wb_req;
        end else if (wb_valid) begin
          win     = wb_req;
          win_vld = 1'b1;
        end else if (fifo_nonempty) begin
          win      = fifo_head;
          win_vld  = 1'b1;
          fifo_pop = 1'b1;
        end
        if (fifo_pop) begin
          starve_cnt_nxt = '0;
        end else if (fifo_nonempty) begin
          if (starve_cnt == 3'(STARVE_LIMIT - 1)) begin
            state_nxt      = FORCE;
            starve_cnt_nxt = '0;
          end else begin
            starve_cnt_nxt = starve_cnt + 3'd1;
          end
        end
      end
      FORCE: begin
        win      = fifo_head;
        win_vld  = fifo_nonempty;
        fifo_pop = fifo_nonempty;
        if (wb_valid) begin
          if (!skid_vld) begin
            skid_nxt     = wb_req;
            skid_vld_nxt = 1'b1;
          end else begin
`ifdef RF_ARB_ERR_EN
            skid_ovf = 1'b1;
`else
            skid_nxt = wb_req;
`endif
          end
        end
        // Leave once the last entry drains and nothing new arrives behind it.
        if (fifo_cnt <= 2'd1 && !fifo_push) state_nxt = NORMAL;
      end
      default: state_nxt = NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= NORMAL;
      starve_cnt     <= '0;
      skid           <= '0;
      skid_vld       <= 1'b0;
      rst_q          <= 1'b1;
      rf_write       <= 1'b0;
      rf_writeregsel <= '0;
      rf_writedata   <= '0;
    end else begin
      state          <= state_nxt;
      starve_cnt     <= starve_cnt_nxt;
      skid           <= skid_nxt;
      skid_vld       <= skid_vld_nxt;
      rst_q          <= 1'b0;
      // r0 is architecturally fixed: the request is consumed without a write.
      rf_write       <= win_vld && (win.sel != 5'd0);
      rf_writeregsel <= win.sel;
      rf_writedata   <= win.dat;
    end
  end

`ifdef RF_ARB_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (skid_ovf) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wr_arb.sv
// Bench for rf_wr_arb: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_rf_wr_arb;

  localparam int SL = 4;

  typedef struct packed {
    logic [4:0]  sel;
    logic [31:0] dat;
  } req_t;

  logic        clk, rst;
  logic        wb_valid, pr_valid, pr_ready, rf_write, stall_req, err;
  logic [4:0]  wb_regsel, pr_regsel, rf_writeregsel;
  logic [31:0] wb_data, pr_data, rf_writedata;
  int          total, bad;

`ifdef RF_ARB_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  // Reference model state
  req_t m_q[$];
  req_t m_skid[$];
  bit   m_force;
  int   m_wait;
  bit   m_err;
  bit   e_wr;
  req_t e_req;

  rf_wr_arb #(.STARVE_LIMIT(SL)) dut (
    .clk            (clk),
    .rst            (rst),
    .wb_valid       (wb_valid),
    .wb_regsel      (wb_regsel),
    .wb_data        (wb_data),
    .pr_valid       (pr_valid),
    .pr_ready       (pr_ready),
    .pr_regsel      (pr_regsel),
    .pr_data        (pr_data),
    .rf_write       (rf_write),
    .rf_writeregsel (rf_writeregsel),
    .rf_writedata   (rf_writedata),
    .stall_req      (stall_req),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  task automatic set_in(input logic wv, input logic [4:0] ws, input logic [31:0] wd,
                        input logic pv, input logic [4:0] ps, input logic [31:0] pd);
    wb_valid = wv; wb_regsel = ws; wb_data = wd;
    pr_valid = pv; pr_regsel = ps; pr_data = pd;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic model_step(input bit wv, input req_t w, input bit pv, input req_t p);
    bit push, had, served, have;
    req_t wn;
    push = pv && (m_q.size() < 2);
    had = (m_q.size() > 0);
    served = 0; have = 0; wn = '0;
    if (m_force) begin
      wn = m_q.pop_front(); have = 1;
      if (wv) begin
        if (m_skid.size() == 0) m_skid.push_back(w);
        else if (ERR_EN) m_err = 1;
        else m_skid[0] = w;
      end
      if (push) m_q.push_back(p);
      m_force = (m_q.size() != 0);
    end else begin
      if (m_skid.size() != 0) begin
        wn = m_skid.pop_front(); have = 1;
        if (wv) m_skid.push_back(w);
      end else if (wv) begin
        wn = w; have = 1;
      end else if (had) begin
        wn = m_q.pop_front(); have = 1; served = 1;
      end
      if (served) m_wait = 0;
      else if (had) begin
        m_wait++;
        if (m_wait == SL) begin m_force = 1; m_wait = 0; end
      end
      if (push) m_q.push_back(p);
    end
    e_wr = have && (wn.sel != 5'd0);
    e_req = wn;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    total++;
    if ({rf_write, rf_writeregsel, rf_writedata, stall_req, err, pr_ready} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", {rf_write, rf_writeregsel, rf_writedata, stall_req, err, pr_ready});
    end
    set_in(1'b1, 5'd7, 32'h1234, 1'b1, 5'd9, 32'h5678);
    @(negedge clk);
    total++;
    if ({rf_write, pr_ready} !== 2'b00) begin
      bad++; $display("FAIL reset_holds got write=%b ready=%b want 0 0", rf_write, pr_ready);
    end
    rst = 1'b0;
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    total++;
    if ({pr_ready, rf_write, stall_req} !== 3'b100) begin
      bad++; $display("FAIL reset_release got ready=%b write=%b stall=%b want 1 0 0", pr_ready, rf_write, stall_req);
    end
  endtask

  task automatic test_single_wb();
    do_reset();
    set_in(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    total++;
    if ({rf_write, rf_writeregsel, rf_writedata} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      bad++; $display("FAIL single_wb got w=%b r%0d %h want 1 r5 deadbeef", rf_write, rf_writeregsel, rf_writedata);
    end
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    total++;
    if (rf_write !== 1'b0) begin bad++; $display("FAIL single_wb_idle got w=%b want 0", rf_write); end
  endtask

  task automatic test_wb_and_pr();
    do_reset();
    set_in(1'b1, 5'd3, 32'h11, 1'b1, 5'd8, 32'h22);
    @(negedge clk);
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    total++;
    if ({rf_write, rf_writeregsel, rf_writedata, stall_req} !== {1'b1, 5'd3, 32'h11, 1'b0}) begin
      bad++; $display("FAIL wb_pr_first got w=%b r%0d %h stall=%b want 1 r3 11 0", rf_write, rf_writeregsel, rf_writedata, stall_req);
    end
    @(negedge clk);
    total++;
    if ({rf_write, rf_writeregsel, rf_writedata, stall_req} !== {1'b1, 5'd8, 32'h22, 1'b0}) begin
      bad++; $display("FAIL wb_pr_second got w=%b r%0d %h stall=%b want 1 r8 22 0", rf_write, rf_writeregsel, rf_writedata, stall_req);
    end
    @(negedge clk);
    total++;
    if (rf_write !== 1'b0) begin bad++; $display("FAIL wb_pr_idle got w=%b want 0", rf_write); end
  endtask

  task automatic test_starvation();
    logic [4:0]  es;
    logic [31:0] ed;
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      set_in(k <= 8, 5'd4, 32'(k), k == 1, 5'd8, 32'hA5);
      @(negedge clk);
      if (k <= 5)      begin es = 5'd4; ed = 32'(k); end
      else if (k == 6) begin es = 5'd8; ed = 32'hA5; end
      else             begin es = 5'd4; ed = 32'(k - 1); end
      total++;
      if (k <= 9) begin
        if ({rf_write, rf_writeregsel, rf_writedata} !== {1'b1, es, ed}) begin
          bad++; $display("FAIL starve_write k=%0d got w=%b r%0d %h want 1 r%0d %h", k, rf_write, rf_writeregsel, rf_writedata, es, ed);
        end
      end else if (rf_write !== 1'b0) begin
        bad++; $display("FAIL starve_idle got w=%b want 0", rf_write);
      end
      total++;
      if (stall_req !== (k == 5)) begin
        bad++; $display("FAIL starve_stall k=%0d got %b want %b", k, stall_req, k == 5);
      end
    end
  endtask

  task automatic test_fifo_full();
    logic [31:0] got[$];
    int pr_n, acc3, first_r8;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      set_in(1'b1, 5'd4, 32'h100 + 32'(c), 1'b1, 5'd8, 32'(c + 1));
      total++;
      if (pr_ready !== (c < 2)) begin
        bad++; $display("FAIL fifo_full_ready c=%0d got %b want %b", c, pr_ready, c < 2);
      end
      @(negedge clk);
    end
    pr_n = 2; acc3 = -1; first_r8 = -1;
    for (int c = 3; c < 30; c++) begin
      if (rf_write === 1'b1 && rf_writeregsel == 5'd8) begin
        got.push_back(rf_writedata);
        if (first_r8 < 0) first_r8 = c;
      end
      set_in(c < 8, 5'd4, 32'h100 + 32'(c), pr_n < 3, 5'd8, 32'(pr_n + 1));
      if (pr_valid && pr_ready) begin pr_n++; acc3 = c; end
      @(negedge clk);
    end
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    total++;
    if (got.size() != 3 || got[0] !== 32'd1 || got[1] !== 32'd2 || got[2] !== 32'd3) begin
      bad++; $display("FAIL fifo_order got n=%0d first=%h want 3 writes 1,2,3", got.size(), (got.size() > 0) ? got[0] : 32'hX);
    end
    total++;
    if (acc3 < 0 || first_r8 < 0 || acc3 < first_r8) begin
      bad++; $display("FAIL fifo_third_push accepted c=%0d first pop seen c=%0d want accept after pop", acc3, first_r8);
    end
  endtask

  task automatic test_r0();
    do_reset();
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFF);
    total++;
    if (pr_ready !== 1'b1) begin bad++; $display("FAIL r0_handshake got ready=%b want 1", pr_ready); end
    @(negedge clk);
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rf_write !== 1'b0) begin bad++; $display("FAIL r0_nowrite i=%0d got w=%b want 0", i, rf_write); end
      @(negedge clk);
    end
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99);
    @(negedge clk);
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    total++;
    if ({rf_write, rf_writeregsel, rf_writedata} !== {1'b1, 5'd9, 32'h99}) begin
      bad++; $display("FAIL r0_drained got w=%b r%0d %h want 1 r9 99", rf_write, rf_writeregsel, rf_writedata);
    end
  endtask

  task automatic test_reset_in_force();
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      set_in(1'b1, 5'd4, 32'(k), k <= 2, 5'd8, 32'h70 + 32'(k));
      @(negedge clk);
    end
    total++;
    if (stall_req !== 1'b1) begin bad++; $display("FAIL rstforce_enter got stall=%b want 1", stall_req); end
    set_in(1'b1, 5'd4, 32'hEE, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if ({rf_write, stall_req} !== 2'b00) begin
        bad++; $display("FAIL rstforce_discard i=%0d got w=%b stall=%b want 0 0", i, rf_write, stall_req);
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] wd, ed;
    logic [4:0]  es;
    bit          ew;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      wd = (k <= 4) ? 32'(k + 1) : ((k == 5) ? 32'hA : 32'hB);
      set_in(k <= 6, 5'd4, wd, k <= 1, 5'd8, 32'h31 + 32'(k));
      @(negedge clk);
      ew = 1; es = 5'd4; ed = 32'(k + 1);
      if (k == 5) begin es = 5'd8; ed = 32'h31; end
      if (k == 6) begin es = 5'd8; ed = 32'h32; end
      if (k == 7) ed = ERR_EN ? 32'hA : 32'hB;
      if (k >= 8) ew = 0;
      total++;
      if (ew) begin
        if ({rf_write, rf_writeregsel, rf_writedata} !== {1'b1, es, ed}) begin
          bad++; $display("FAIL ovf_write k=%0d got w=%b r%0d %h want 1 r%0d %h", k, rf_write, rf_writeregsel, rf_writedata, es, ed);
        end
      end else if (rf_write !== 1'b0) begin
        bad++; $display("FAIL ovf_idle k=%0d got w=%b want 0", k, rf_write);
      end
      total++;
      if (err !== (ERR_EN && k >= 6)) begin
        bad++; $display("FAIL ovf_err k=%0d got %b want %b", k, err, ERR_EN && k >= 6);
      end
      total++;
      if (stall_req !== (k == 4 || k == 5)) begin
        bad++; $display("FAIL ovf_stall k=%0d got %b want %b", k, stall_req, k == 4 || k == 5);
      end
    end
    rst = 1'b1;
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL ovf_err_reset got %b want 0", err); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    req_t w, p;
    bit   wv, pv;
    int   wrate;
    do_reset();
    m_q.delete(); m_skid.delete();
    m_force = 0; m_wait = 0; m_err = 0; e_wr = 0; e_req = '0;
    for (int c = 0; c < 3000; c++) begin
      total++;
      if (e_wr) begin
        if ({rf_write, rf_writeregsel, rf_writedata} !== {1'b1, e_req}) begin
          bad++; $display("FAIL rand_write c=%0d got w=%b r%0d %h want 1 r%0d %h", c, rf_write, rf_writeregsel, rf_writedata, e_req.sel, e_req.dat);
        end
      end else if (rf_write !== 1'b0) begin
        bad++; $display("FAIL rand_nowrite c=%0d got w=%b want 0", c, rf_write);
      end
      total++;
      if (stall_req !== m_force) begin bad++; $display("FAIL rand_stall c=%0d got %b want %b", c, stall_req, m_force); end
      total++;
      if (pr_ready !== (m_q.size() < 2)) begin bad++; $display("FAIL rand_ready c=%0d got %b want %b", c, pr_ready, m_q.size() < 2); end
      total++;
      if (err !== m_err) begin bad++; $display("FAIL rand_err c=%0d got %b want %b", c, err, m_err); end
      wrate = ((c / 300) % 2 == 1) ? 85 : 40;
      wv = ($urandom_range(0, 99) < wrate);
      pv = ($urandom_range(0, 99) < 45);
      w.sel = 5'($urandom_range(0, 31)); w.dat = $urandom;
      p.sel = 5'($urandom_range(0, 31)); p.dat = $urandom;
      set_in(wv, w.sel, w.dat, pv, p.sel, p.dat);
      model_step(wv, w, pv, p);
      @(negedge clk);
    end
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1;
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    test_reset();
    test_single_wb();
    test_wb_and_pr();
    test_starvation();
    test_fifo_full();
    test_r0();
    test_reset_in_force();
    test_overflow();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_wr_arb.md
RF_WR_ARB -- requirements
Module: rf_wr_arb

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, legal 1..7: consecutive ungranted cycles before the peripheral write is forced.
REQ-002 SHALL have ports clk  in  1  clock; rst  in  1  reset. There is one clock, and reset is synchronous and active-high.
REQ-003 SHALL have ports wb_valid  in  1, wb_regsel  in  5, wb_data  in  32. These carry the pipeline writeback request, which has no ready signal.
REQ-004 SHALL have ports pr_valid  in  1, pr_ready  out  1, pr_regsel  in  5, pr_data  in  32. These carry the peripheral (input/line-status) write request using a valid/ready handshake.
REQ-005 SHALL have ports rf_write  out  1, rf_writeregsel  out  5, rf_writedata  out  32. These drive the register-file write port; all three are registered.
REQ-006 SHALL have ports stall_req  out  1 (registered pipeline stall request) and err  out  1 (sticky overflow flag).

Function
REQ-007 SHALL pick one winner per cycle N and present it on the rf_* outputs in cycle N+1, giving 1-cycle latency; rf_write SHALL be 0 when there is no winner.
REQ-008 SHALL buffer peripheral requests in a 2-entry FIFO; pr_ready = (registered count < 2), and a push SHALL occur on pr_valid && pr_ready.
REQ-009 SHALL NOT raise pr_ready in the same cycle when the FIFO is full and popped that cycle; the push capacity returns on the following cycle.
REQ-010 SHALL hold a 1-entry skid register for writebacks that arrive during FORCE.
REQ-011 SHALL implement states NORMAL and FORCE; stall_req = (state == FORCE).
REQ-012 In NORMAL, priority SHALL be: skid entry, then wb_valid, then FIFO head.
REQ-013 Starvation counter: increments each NORMAL cycle in which the FIFO is non-empty and the head is not granted; clears when the head is granted.
REQ-014 When the counter reaches STARVE_LIMIT, the block SHALL enter FORCE on the next edge and clear the counter.
REQ-015 In FORCE, the FIFO head SHALL win every cycle regardless of wb_valid; any concurrent wb_valid SHALL be captured into the skid register.
REQ-016 FORCE SHALL return to NORMAL on the edge after the cycle that pops the last FIFO entry; entries pushed during FORCE extend FORCE.
REQ-017 A granted request with regsel 0 SHALL be consumed with rf_write = 0.
REQ-018 A wb_valid arriving in FORCE while the skid register is full is an overflow; see REQ-023.
REQ-019 Simultaneous push and pop on a non-full FIFO SHALL keep the count unchanged and preserve FIFO order.

Reset
REQ-020 While rst is high on a clk edge, the block SHALL set state = NORMAL, empty the FIFO and skid register, and clear the counter.
REQ-021 Reset SHALL force rf_write = 0, rf_writeregsel = 0, rf_writedata = 0, stall_req = 0, err = 0, and pr_ready = 0 for the cycle after the reset edge; pr_ready = 1 on the first cycle after rst falls.
REQ-022 A reset during FORCE SHALL discard all pending requests, with no write issued afterward.

Configuration
REQ-023 Macro RF_ARB_ERR_EN: when defined, an overflow sets err = 1 (sticky until reset) and the new writeback is dropped, keeping the old skid contents. When undefined, err is tied 0 and the new writeback overwrites the skid contents.

Verification
REQ-024 wb_valid = 1, r5, 0xDEADBEEF in cycle 0 -> cycle 1: rf_write = 1, sel = 5, data = 0xDEADBEEF; cycle 2: rf_write = 0.
REQ-025 Cycle 0: wb r3 = 0x11 and pr r8 = 0x22 together, with wb idle afterward -> cycle 1 writes r3 = 0x11, cycle 2 writes r8 = 0x22, stall_req stays 0.
REQ-026 FIFO holds r8 = 0xA5 and wb_valid is continuous (r4 = 0x1, 0x2, ...) with STARVE_LIMIT = 4 -> after 4 ungranted cycles, stall_req = 1 and r8 = 0xA5 is written in the first FORCE cycle + 1. The wb of that cycle enters the skid register and is written first after the return to NORMAL, then stall_req = 0.
REQ-027 Three back-to-back pr pushes (r8 = 0x1, 0x2, 0x3) while wb is busy -> pr_ready = 0 after 2 accepts. The third push is held until after the first pop, and all three are written in order 0x1, 0x2, 0x3.
REQ-028 A pr request to r0 with data 0xFF -> pr_ready handshake completes, rf_write never asserts, and the FIFO empties.
REQ-029 With RF_ARB_ERR_EN defined, two wb_valid pulses (0xA then 0xB) in FORCE -> err = 1, the skid register still holds 0xA, 0xB is never written, and err remains 1 until rst.
